dvi_timing_ctrl: RTL and testbench

//  Video timing controller and pixel-fetch scheduler that sequences the DVI output datapath.
//  - Counters: horizontal/vertical, generating hsync, vsync and ve.
//  - Fetch control: issues per-line fetch requests and pops pixels from an upstream FIFO.
//  - Output: registered 8-bit red/green/blue aligned with the sync signals.
//  - Placement: between the frame-fetch logic and the DVI transmitter, replacing the free-running stimulus source.

---
 rtl/dvi_pkg.sv | 40 ++++
 rtl/dvi_timing_ctrl_if.sv | 45 ++++
 rtl/dvi_tc_counter.sv | 30 +++
 rtl/dvi_timing_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dvi_timing_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dvi_pkg.sv
// dvi_pkg: shared state type and default 640x480 timing constants
// for the DVI timing controller and its counters.
package dvi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam bit HS_POL_D   = 1'b0;
  localparam bit VS_POL_D   = 1'b0;

  function automatic int span(
    input int a,
    input int b,
    input int c,
    input int d
  );
    return a + b + c + d;
  endfunction

  localparam int H_TOTAL =
    span(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
  localparam int V_TOTAL =
    span(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);

  localparam int H_SYNC_START = H_ACTIVE_D + H_FP_D;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_D;
  localparam int V_SYNC_START = V_ACTIVE_D + V_FP_D;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_D;

endpackage

// File: rtl/dvi_timing_ctrl_if.sv
// dvi_timing_ctrl_if: pixel-fetch side and video-out side of the
// timing controller bundled as one interface.
interface dvi_timing_ctrl_if;

  logic [23:0] pix_data;
  logic        pix_empty;
  logic        pix_rd;
  logic        line_req;
  logic [9:0]  line_y;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        ve;

  modport master (
    input  pix_data,
    input  pix_empty,
    output pix_rd,
    output line_req,
    output line_y,
    output red,
    output green,
    output blue,
    output hsync,
    output vsync,
    output ve
  );

  modport slave (
    output pix_data,
    output pix_empty,
    input  pix_rd,
    input  line_req,
    input  line_y,
    input  red,
    input  green,
    input  blue,
    input  hsync,
    input  vsync,
    input  ve
  );

endinterface

// File: rtl/dvi_tc_counter.sv
// dvi_tc_counter: loadable wrap counter with terminal-count flag,
// used for both the horizontal and vertical position.
module dvi_tc_counter #(
  parameter int W   = 10,
  parameter int MAX = 799
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MAX);

  assign tc = (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/dvi_timing_ctrl.sv
// dvi_timing_ctrl: video timing, line-fetch scheduling and a
// two-stage output pipeline feeding the DVI transmitter.
module dvi_timing_ctrl
  import dvi_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter bit HS_POL   = HS_POL_D,
  parameter bit VS_POL   = VS_POL_D
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic stop,
  dvi_timing_ctrl_if.master vid,
  output logic underflow,
  output logic busy
);

  localparam int HT = span(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = span(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0] HA  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS0 = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS1 = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VA  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS0 = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS1 = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] VLAST = VW'(VT - 1);

  state_t        state;
  logic          stop_pend;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_tc;
  logic          v_tc;
  logic          run;
  logic          go;
  logic          frame_end;

  assign run       = (state == RUN);
  assign go        = !run && start && !stop;
  assign frame_end = run && h_tc && v_tc && stop_pend;
  assign busy      = run;

  // A start parks v on the last line so line 0 gets fetched first.
  dvi_tc_counter #(.W(HW), .MAX(HT - 1)) u_h (
    .clock    (clock),
    .reset    (reset),
    .en       (run),
    .load     (go),
    .load_val ('0),
    .cnt      (h),
    .tc       (h_tc)
  );

  dvi_tc_counter #(.W(VW), .MAX(VT - 1)) u_v (
    .clock    (clock),
    .reset    (reset),
    .en       (run && h_tc),
    .load     (go),
    .load_val (VLAST),
    .cnt      (v),
    .tc       (v_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      stop_pend <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          if (start && !stop) state <= RUN;
        end
        RUN: begin
          if (frame_end) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end
      endcase
    end
  end

  logic [VW-1:0] vn;
  logic          act0;
  logic          hs0;
  logic          vs0;

  assign vn   = v_tc ? '0 : v + VW'(1);
  assign act0 = run && (h < HA) && (v < VA);
  assign hs0  = run && (h >= HS0) && (h < HS1);
  assign vs0  = run && (v >= VS0) && (v < VS1);

  assign vid.pix_rd   = act0;
  assign vid.line_y   = 10'(vn);
  assign vid.line_req = run && (h == HA) && (vn < VA)
                        && !((vn == '0) && stop_pend);

  logic act1;
  logic hs1;
  logic vs1;
  logic emp1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act1 <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      emp1 <= 1'b0;
    end else begin
      act1 <= act0;
      hs1  <= hs0;
      vs1  <= vs0;
      emp1 <= act0 && vid.pix_empty;
    end
  end

  logic [23:0] rgb_q;
  logic        hs_q;
  logic        vs_q;
  logic        ve_q;

  // Read data arrives one clock after the pop, i.e. alongside stage 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb_q     <= '0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      ve_q      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rgb_q     <= (act1 && !emp1) ? vid.pix_data : '0;
      hs_q      <= hs1 ? HS_POL : ~HS_POL;
      vs_q      <= vs1 ? VS_POL : ~VS_POL;
      ve_q      <= act1;
      underflow <= go ? 1'b0 : (underflow | emp1);
    end
  end

  assign vid.red   = rgb_q[23:16];
  assign vid.green = rgb_q[15:8];
  assign vid.blue  = rgb_q[7:0];
  assign vid.hsync = hs_q;
  assign vid.vsync = vs_q;
  assign vid.ve    = ve_q;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// tb_dvi_timing_ctrl: reduced-timing bench with a frame-position
// reference model and a registered-read FIFO stand-in.
module tb_dvi_timing_ctrl;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 2;
  localparam int HB = 2;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stop  = 1'b0;
  logic underflow;
  logic busy;

  dvi_timing_ctrl_if vif ();

  dvi_timing_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL   (1'b0), .VS_POL (1'b0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .vid       (vif),
    .underflow (underflow),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        ve;
    logic        emp;
    logic [23:0] px;
  } tup_t;

  bit   m_run  = 0;
  bit   m_pend = 0;
  bit   m_uf   = 0;
  int   m_t    = 0;
  int   m_ramp = 0;
  int   env_cnt = 0;
  int   cyc    = 0;
  tup_t d1     = '0;
  tup_t d2     = '0;

  function automatic int mh();
    return m_t % HT;
  endfunction

  function automatic int mv();
    return (m_t / HT + VT - 1) % VT;
  endfunction

  task automatic check_all();
    int h, v, n;
    bit rd, lr;
    h  = mh();
    v  = mv();
    n  = (v + 1) % VT;
    rd = m_run && h < HA && v < VA;
    lr = m_run && h == HA && n < VA && !(n == 0 && m_pend);
    chk("pix_rd", 32'(vif.pix_rd), 32'(rd));
    chk("line_req", 32'(vif.line_req), 32'(lr));
    if (lr) chk("line_y", 32'(vif.line_y), n);
    chk("ve", 32'(vif.ve), 32'(d2.ve));
    chk("hsync", 32'(vif.hsync), 32'(!d2.hs));
    chk("vsync", 32'(vif.vsync), 32'(!d2.vs));
    chk("rgb", {8'h0, vif.red, vif.green, vif.blue}, {8'h0, d2.px});
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("busy", 32'(busy), 32'(m_run));
  endtask

  task automatic step();
    int h, v;
    bit rd, go, e_pop, e_emp;
    tup_t s0;
    h  = mh();
    v  = mv();
    rd = m_run && h < HA && v < VA;
    s0.hs  = m_run && h >= HA + HF && h < HA + HF + HS;
    s0.vs  = m_run && v >= VA + VF && v < VA + VF + VS;
    s0.ve  = rd;
    s0.emp = rd && vif.pix_empty;
    s0.px  = '0;
    if (rd && !vif.pix_empty) begin
      m_ramp++;
      s0.px = 24'(m_ramp);
    end
    e_pop = vif.pix_rd;
    e_emp = vif.pix_empty;
    @(posedge clock);
    cyc++;
    go   = !m_run && start && !stop;
    m_uf = go ? 1'b0 : (m_uf | d1.emp);
    d2   = d1;
    d1   = s0;
    if (!m_run) begin
      if (go) begin
        m_run  = 1;
        m_t    = 0;
        m_pend = 0;
      end
    end else begin
      if ((m_t % FT) == HT - 1 && m_pend) begin
        m_run  = 0;
        m_pend = 0;
      end else if (stop) begin
        m_pend = 1;
      end
      m_t++;
    end
    #1;
    if (e_pop) begin
      if (!e_emp) begin
        env_cnt++;
        vif.pix_data = 24'(env_cnt);
      end else begin
        vif.pix_data = 24'($urandom);
      end
    end
    @(negedge clock);
    check_all();
  endtask

  task automatic wait_pos(input int vv, input int hh, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (m_run && mv() == vv && mh() == hh) break;
      step();
    end
    if (i == budget) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_pos: v=%0d h=%0d not reached in %0d", vv, hh, budget);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_ve", 32'(vif.ve), 0);
    chk("rst_rgb", {8'h0, vif.red, vif.green, vif.blue}, 0);
    chk("rst_pix_rd", 32'(vif.pix_rd), 0);
    chk("rst_line_req", 32'(vif.line_req), 0);
    chk("rst_hsync", 32'(vif.hsync), 1);
    chk("rst_vsync", 32'(vif.vsync), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_underflow", 32'(underflow), 0);
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_pend = 0;
    m_uf   = 0;
    d1     = '0;
    d2     = '0;
  endtask

  // Start from IDLE and measure first-frame timing relationships.
  task automatic first_frame();
    int st, rd_f, lr_f, ve_f, hs_f, vs_f, nve, nvs, nhs;
    rd_f = -1; lr_f = -1; ve_f = -1; hs_f = -1; vs_f = -1;
    nve = 0; nvs = 0; nhs = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    st = cyc;
    for (int i = 0; i < FT + 40; i++) begin
      if (vif.line_req && lr_f < 0) lr_f = cyc;
      step();
      if (vif.pix_rd && rd_f < 0) rd_f = cyc;
      if (vif.ve && ve_f < 0) ve_f = cyc;
      if (ve_f >= 0 && cyc - ve_f < FT) begin
        if (vif.ve) nve++;
        if (!vif.vsync) nvs++;
        if (!vif.hsync) nhs++;
        if (!vif.vsync && vs_f < 0) vs_f = cyc;
        if (!vif.hsync && hs_f < 0) hs_f = cyc;
      end
    end
    chk("lr_ofs", lr_f - st, 8);
    chk("rd_ofs", rd_f - st, HT);
    chk("ve_lat", ve_f - rd_f, 2);
    chk("ve_cnt", nve, HA * VA);
    chk("hs_ofs", hs_f - ve_f, HA + HF);
    chk("hs_cnt", nhs, HS * VT);
    chk("vs_ofs", vs_f - ve_f, (VA + VF) * HT);
    chk("vs_cnt", nvs, VS * HT);
  endtask

  initial begin
    int i;
    vif.pix_data  = '0;
    vif.pix_empty = 1'b0;
    @(negedge clock);
    chk_reset_vals();
    @(negedge clock);
    reset = 1'b0;
    check_all();

    first_frame();

    wait_pos(2, 3, 2 * FT);
    vif.pix_empty = 1'b1;
    step();
    vif.pix_empty = 1'b0;
    for (i = 0; i < 4; i++) step();
    chk("uf_set", 32'(underflow), 1);

    wait_pos(1, 4, 2 * FT);
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (i = 0; i < 3 * FT && busy; i++) step();
    chk("stop_idle", 32'(busy), 0);
    chk("uf_hold", 32'(underflow), 1);
    for (i = 0; i < 10; i++) step();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    step();
    chk("busy_ss", 32'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("uf_clr", 32'(underflow), 0);

    for (i = 0; i < 700; i++) begin
      start         = ($urandom % 20) == 0;
      stop          = ($urandom % 150) == 0;
      vif.pix_empty = ($urandom % 12) == 0;
      step();
    end
    start = 1'b0;
    stop  = 1'b1;
    vif.pix_empty = 1'b0;
    step();
    stop = 1'b0;
    for (i = 0; i < 3 * FT && m_run; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_pos(1, 3, 2 * FT);

    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals();
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_all();
    for (i = 0; i < 5; i++) step();
    first_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
